// File: rtl/counter_disp_pkg.sv
// Shared types and constants for the counter 7-segment display path.
// Segment codes are {g,f,e,d,c,b,a}, active-high.
package counter_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    typedef struct packed {
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd3_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_ITER   = 8;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 9-bit magnitude to three BCD nibbles.
// One shift per cycle, then a single DONE cycle exposing the result.
module bin2bcd_seq
    import counter_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] mag,
    output logic       busy,
    output logic       done,
    output bcd3_t      bcd
);

    bcd_state_t  state;
    logic [2:0]  iter;
    logic [11:0] acc;
    logic [7:0]  bin;
    logic [11:0] adj;
    logic [7:0]  load;

    // Magnitudes never exceed 255; bit 8 only saturates an impossible input.
    assign load = mag[8] ? 8'hFF : mag[7:0];

    always_comb begin
        adj = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            iter  <= '0;
            acc   <= '0;
            bin   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        bin   <= load;
                        iter  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, bin} <= {adj[10:0], bin, 1'b0};
                    iter       <= iter + 3'd1;
                    if (iter == 3'(BCD_ITER - 1))
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = acc;

endmodule

// File: rtl/counter_seg_display.sv
// Counter value to 4-digit multiplexed 7-segment display (sign, hundreds,
// tens, ones) with optional two's-complement interpretation.
module counter_seg_display
    import counter_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 16
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            value,
    input  logic                  signed_en,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    // The pin keeps its legacy name but is an active-high reset.
    logic rst;
    assign rst = rst_n;

    logic       neg_in;
    logic [8:0] mag_in;
    logic [8:0] key_in;
    logic [8:0] last_key;
    logic       neg_snap;
    logic       valid;
    logic       start;
    logic       conv_busy;
    logic       conv_done;
    bcd3_t      conv_bcd;
    bcd3_t      disp;
    logic       disp_neg;

    logic [RW-1:0] rcnt;
    logic [IW-1:0] idx;
    logic [6:0]    nxt_seg;

    assign neg_in = signed_en & value[7];
    assign mag_in = neg_in ? (9'd0 - {value[7], value}) : {1'b0, value};
    assign key_in = {signed_en, value};
    assign start  = !conv_busy && (!valid || (key_in != last_key));

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mag   (mag_in),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign busy = conv_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_key <= '0;
            neg_snap <= 1'b0;
            valid    <= 1'b0;
            disp     <= '0;
            disp_neg <= 1'b0;
        end else begin
            if (start) begin
                last_key <= key_in;
                neg_snap <= neg_in;
            end
            if (conv_done) begin
                disp     <= conv_bcd;
                disp_neg <= neg_snap;
                valid    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= idx + 1'b1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    always_comb begin
        nxt_seg = SEG_BLANK;
        unique case (idx)
            2'd0: nxt_seg = seg_code(disp.ones);
            2'd1: nxt_seg = (disp.hund == 4'd0 && disp.tens == 4'd0)
                            ? SEG_BLANK : seg_code(disp.tens);
            2'd2: nxt_seg = (disp.hund == 4'd0)
                            ? SEG_BLANK : seg_code(disp.hund);
            2'd3: nxt_seg = disp_neg ? SEG_MINUS : SEG_BLANK;
            default: nxt_seg = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= '0;
            an  <= '0;
        end else begin
            seg <= nxt_seg;
            an  <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
        end
    end

endmodule

// File: tb/tb_counter_seg_display.sv
// Directed bench for counter_seg_display with a fast refresh divider.
module tb_counter_seg_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] value;
    logic       signed_en;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] dig [4];
    logic       bh  [25];

    counter_seg_display #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .signed_en (signed_en),
        .seg       (seg),
        .an        (an),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_digits(input string tag, input logic [6:0] e3,
                                input logic [6:0] e2, input logic [6:0] e1,
                                input logic [6:0] e0);
        for (int k = 0; k < 4; k++) dig[k] = 7'h7F;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            case (an)
                4'b0001: dig[0] = seg;
                4'b0010: dig[1] = seg;
                4'b0100: dig[2] = seg;
                4'b1000: dig[3] = seg;
                default: check({tag, "_onehot"}, 32'(an), 32'h1);
            endcase
        end
        check({tag, "_d0"}, 32'(dig[0]), 32'(e0));
        check({tag, "_d1"}, 32'(dig[1]), 32'(e1));
        check({tag, "_d2"}, 32'(dig[2]), 32'(e2));
        check({tag, "_d3"}, 32'(dig[3]), 32'(e3));
    endtask

    initial begin
        int nb;
        int gap;
        logic [3:0] prev;
        rst_n     = 1'b1;
        value     = 8'd0;
        signed_en = 1'b0;

        // 1: reset state, first conversion of 0
        cycles(2);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_an", 32'(an), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b0;
        nb = 0;
        for (int s = 1; s <= 15; s++) begin
            @(negedge clk);
            if (s == 1) begin
                check("t1_an_first", 32'(an), 32'h1);
                check("t1_seg_first", 32'(seg), 32'h3F);
            end
            if (busy) nb++;
        end
        check("t1_busy_cycles", 32'(nb), 32'd9);
        check_digits("t1", 7'h00, 7'h00, 7'h00, 7'h3F);

        // 2: 255 unsigned, digit rotation order
        value = 8'd255;
        cycles(12);
        check_digits("t2", 7'h00, 7'h5B, 7'h6D, 7'h6D);
        prev = an;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            if (an != prev) begin
                check("t2_an_order", 32'(an), 32'({prev[2:0], prev[3]}));
                prev = an;
            end
        end

        // 3: -10 signed, then same byte as unsigned 246
        value     = 8'hF6;
        signed_en = 1'b1;
        cycles(12);
        check_digits("t3s", 7'h40, 7'h00, 7'h06, 7'h3F);
        signed_en = 1'b0;
        cycles(12);
        check_digits("t3u", 7'h00, 7'h5B, 7'h66, 7'h7D);

        // 4: -128 and 128
        value     = 8'h80;
        signed_en = 1'b1;
        cycles(12);
        check_digits("t4s", 7'h40, 7'h06, 7'h5B, 7'h7F);
        signed_en = 1'b0;
        cycles(12);
        check_digits("t4u", 7'h00, 7'h06, 7'h5B, 7'h7F);

        // 5: change 5 -> 7 while the first conversion is shifting
        value = 8'd5;
        for (int s = 1; s <= 24; s++) begin
            @(negedge clk);
            bh[s] = busy;
            if (s == 3) value = 8'd7;
            if (s == 9) check("t5_no_early", 32'(dut.disp.ones), 32'd8);
            if (s == 10) check("t5_latch5", 32'(dut.disp.ones), 32'd5);
        end
        nb  = 0;
        gap = 0;
        for (int s = 1; s <= 24; s++) begin
            if (bh[s]) nb++;
            if (s <= 19 && !bh[s]) gap++;
        end
        check("t5_busy_total", 32'(nb), 32'd18);
        check("t5_idle_gap", 32'(gap), 32'd1);
        check_digits("t5", 7'h00, 7'h00, 7'h00, 7'h07);

        // 6: async reset mid-conversion, then reconversion
        value = 8'd200;
        cycles(4);
        check("t6_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b1;
        #1;
        check("t6_seg_async", 32'(seg), 32'h0);
        check("t6_an_async", 32'(an), 32'h0);
        check("t6_busy_async", 32'(busy), 32'h0);
        cycles(2);
        rst_n = 1'b0;
        cycles(1);
        check("t6_an_rel", 32'(an), 32'h1);
        check("t6_seg_rel", 32'(seg), 32'h3F);
        check("t6_busy_rel", 32'(busy), 32'h1);
        cycles(12);
        check_digits("t6", 7'h00, 7'h5B, 7'h3F, 7'h3F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
